uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Parametrised UART transmitter with an input FIFO, runtime baud divisor, optional parity and 1/2 stop bits. It is the next-generation transmit path: it accepts words over a valid/ready stream from bus-side logic, buffers them, and serialises them back-to-back on `tx` with no idle gap between queued frames. Frame format is latched per frame, so software can reconfigure between frames without corrupting one in flight.

## Interface
- `DATA_WIDTH`, 8: bits per character, legal range 5..9.
- `FIFO_DEPTH`, 4: input FIFO entries, power of two, ≥2.
- `DIV_WIDTH`, 16: width of the baud divisor.
- `clk`  in  1  single clock for all logic.
- `rst_n`  in  1  asynchronous, active-low reset.
- `baud_div`  in  DIV_WIDTH  clock cycles per bit; values 0 and 1 are treated as 2.
- `parity_mode`  in  2  00 none, 01 even, 10 odd, 11 none.
- `stop2`  in  1  0 = one stop bit, 1 = two stop bits.
- `s_valid`  in  1  input word valid.
- `s_ready`  out  1  FIFO can accept a word.
- `s_data`  in  DATA_WIDTH  character, transmitted LSB first.
- `tx`  out  1  serial line, idle high, registered.
- `tx_busy`  out  1  high when the FSM is not IDLE or the FIFO is non-empty.
- `tx_done`  out  1  one-cycle pulse at the end of each frame's last stop bit.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- Reset values: `tx`=1, `s_ready`=1, `tx_busy`=0, `tx_done`=0, `fifo_count`=0. FIFO pointers cleared, FSM in IDLE.
- Reset asserted mid-frame: `tx` returns high immediately. Queued words are discarded.
- FIFO push occurs on an edge where `s_valid && s_ready`.
- `s_ready` = (`fifo_count` < FIFO_DEPTH). It does not depend on `s_valid`.
- Simultaneous push and pop leave the count unchanged. Push never occurs when full. Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE to START when the FIFO is non-empty. On that edge:
  - pop the head word into the shift register;
  - latch `baud_div` (clamped to ≥2), `parity_mode` and `stop2` for the whole frame;
  - drive `tx` to 0.
- START to DATA after `baud_div` cycles.
- DATA shifts out DATA_WIDTH bits LSB first, each held `baud_div` cycles.
- DATA exits to PARITY if parity is enabled for this frame, otherwise to STOP.
- PARITY holds one bit for `baud_div` cycles:
  - even mode: the XOR of the data bits;
  - odd mode: its complement.
- STOP drives `tx`=1 for 1 or 2 bit periods. When they finish, `tx_done` pulses, then:
  - FIFO non-empty: go directly to START (pop and `tx`=0 on the same edge);
  - FIFO empty: go to IDLE.
- Bit timer and bit counter are zeroed on every state transition. Cycle counter width is DIV_WIDTH, bit counter width is $clog2(DATA_WIDTH)+1.

## Timing
- Word pushed into an empty FIFO while idle at edge N: popped and `tx` falls at edge N+1.
- Each bit lasts exactly `baud_div` clk cycles.
- Frame length = `baud_div` × (1 + DATA_WIDTH + P + S), where P ∈ {0,1} and S ∈ {1,2}.
- `tx_done` is high for the single cycle following the final stop-bit edge, and coincides with the next START when words are queued.
- Back-to-back frames have zero idle cycles between them.
- Changes to `baud_div`, `parity_mode` or `stop2` mid-frame take effect at the next frame start only.

## Configuration
- `UART_TX_PARITY_EN` defined: PARITY state and parity generation are present, and `parity_mode` is honoured.
- `UART_TX_PARITY_EN` undefined: PARITY logic is compiled out. `parity_mode` is ignored (port retained), DATA goes straight to STOP, and every frame is parity-less.

## Test plan
- Reset, then idle 20 cycles: `tx`=1, `s_ready`=1, `tx_busy`=0, `fifo_count`=0.
- `baud_div`=4, even parity, `stop2`=0, push 0xA5:
  - `tx` falls one edge after the push;
  - bits in 4-cycle slots: 0, 1,0,1,0,0,1,0,1, parity 0, stop 1 (44 cycles);
  - `tx_done` pulses once.
- `baud_div`=4, odd parity, `stop2`=1, push 0x01: parity bit 0, `tx` high for 8 cycles, frame 48 cycles.
- Hold `s_valid`=1 with 0x11..0x16 while `baud_div`=3:
  - `s_ready` drops when `fifo_count`=4;
  - all six words transmit in order with zero-gap frames;
  - `tx_done` pulses six times, then `tx_busy`=0.
- Change `baud_div` from 4 to 8 mid-frame: the current frame stays at 4 cycles/bit, the next frame uses 8.
- Assert `rst_n`=0 during the DATA bits of a queued burst:
  - `tx`=1 asynchronously;
  - after release `fifo_count`=0 and no further frames are sent.

Source files
------------

// File: rtl/uart_tx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : UART transmitter fed by a small valid/ready input FIFO. Queued
//            words are serialised back-to-back with no idle gap. The baud
//            divisor, parity mode and stop-bit count are latched when each
//            frame starts, so they can be changed freely between frames.
//
// Ports    : clk          - single clock
//            rst_n        - asynchronous active-low reset
//            baud_div     - clock cycles per bit (0 and 1 behave as 2)
//            parity_mode  - 00 none, 01 even, 10 odd, 11 none
//            stop2        - 0 one stop bit, 1 two stop bits
//            s_valid      - input word valid
//            s_ready      - FIFO can accept a word
//            s_data       - character, sent LSB first
//            tx           - serial line, idle high, registered
//            tx_busy      - FSM active or FIFO non-empty
//            tx_done      - one-cycle pulse after each frame's last stop bit
//            fifo_count   - current FIFO occupancy
//
// Config   : define UART_TX_PARITY_EN to build the parity state and honour
//            parity_mode; without it every frame is sent without parity.
//
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [DIV_WIDTH-1:0]        baud_div,
    input  logic [1:0]                  parity_mode,
    input  logic                        stop2,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [DATA_WIDTH-1:0]       s_data,
    output logic                        tx,
    output logic                        tx_busy,
    output logic                        tx_done,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam int c_BW = $clog2(DATA_WIDTH) + 1;

    localparam logic [c_CW-1:0]      c_FULL     = c_CW'(FIFO_DEPTH);
    localparam logic [c_BW-1:0]      c_LAST_BIT = c_BW'(DATA_WIDTH - 1);
    localparam logic [DIV_WIDTH-1:0] c_MIN_DIV  = DIV_WIDTH'(2);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
    localparam logic [2:0] c_ST_STOP   = 3'd4;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] c_ST_PARITY = 3'd3;
`endif

    // ------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]       r_wr_ptr;
    logic [c_AW-1:0]       r_rd_ptr;
    logic [c_CW-1:0]       r_count;

    // ------------------------------------------------------------------
    // Transmit state
    // ------------------------------------------------------------------
    logic [2:0]            r_state;
    logic [2:0]            w_state_next;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DIV_WIDTH-1:0]  r_div;
    logic [DIV_WIDTH-1:0]  r_cyc;
    logic [c_BW-1:0]       r_bitcnt;
    logic                  r_stop2;
    logic                  r_tx;
    logic                  r_done;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_nonempty;
    logic                  w_bit_end;
    logic                  w_frame_end;
    logic [DIV_WIDTH-1:0]  w_div_eff;
    logic [DATA_WIDTH-1:0] w_head;

`ifdef UART_TX_PARITY_EN
    logic                  r_par_en;
    logic                  r_par;
`else
    // Port kept for pin compatibility; nothing consumes it in this build.
    logic                  w_unused_parity;
    assign w_unused_parity = ^parity_mode;
`endif

    assign s_ready    = (r_count < c_FULL);
    assign w_push     = s_valid && s_ready;
    assign w_nonempty = (r_count != '0);
    assign w_head     = r_mem[r_rd_ptr];
    assign w_div_eff  = (baud_div < c_MIN_DIV) ? c_MIN_DIV : baud_div;
    assign w_bit_end  = (r_cyc == r_div - DIV_WIDTH'(1));

    assign tx         = r_tx;
    assign tx_done    = r_done;
    assign tx_busy    = (r_state != c_ST_IDLE) || w_nonempty;
    assign fifo_count = r_count;

    // ------------------------------------------------------------------
    // Next-state logic. A pop always coincides with entry into START,
    // either from IDLE or directly from the end of the previous STOP.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_frame_end  = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_nonempty) begin
                    w_state_next = c_ST_START;
                    w_pop        = 1'b1;
                end
            end
            c_ST_START: begin
                if (w_bit_end) w_state_next = c_ST_DATA;
            end
            c_ST_DATA: begin
                if (w_bit_end && (r_bitcnt == c_LAST_BIT)) begin
`ifdef UART_TX_PARITY_EN
                    w_state_next = r_par_en ? c_ST_PARITY : c_ST_STOP;
`else
                    w_state_next = c_ST_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            c_ST_PARITY: begin
                if (w_bit_end) w_state_next = c_ST_STOP;
            end
`endif
            c_ST_STOP: begin
                // Last stop bit is index 0 for one stop bit, 1 for two.
                if (w_bit_end && (r_bitcnt == {{(c_BW-1){1'b0}}, r_stop2})) begin
                    w_frame_end = 1'b1;
                    if (w_nonempty) begin
                        w_state_next = c_ST_START;
                        w_pop        = 1'b1;
                    end else begin
                        w_state_next = c_ST_IDLE;
                    end
                end
            end
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO write port (storage is not reset; occupancy guards reads)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= s_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State register, bit timing and serial output
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_ST_IDLE;
            r_shift  <= '0;
            r_div    <= c_MIN_DIV;
            r_cyc    <= '0;
            r_bitcnt <= '0;
            r_stop2  <= 1'b0;
            r_tx     <= 1'b1;
            r_done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_par_en <= 1'b0;
            r_par    <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;
            r_done  <= w_frame_end;

            // Frame parameters are captured only at the pop edge.
            if (w_pop) begin
                r_div   <= w_div_eff;
                r_stop2 <= stop2;
`ifdef UART_TX_PARITY_EN
                r_par_en <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
                r_par    <= (^w_head) ^ (parity_mode == 2'b10);
`endif
            end

            if (w_pop) begin
                r_shift <= w_head;
            end else if ((r_state == c_ST_DATA) && w_bit_end) begin
                r_shift <= r_shift >> 1;
            end

            if (w_state_next != r_state) begin
                r_cyc    <= '0;
                r_bitcnt <= '0;
            end else if (r_state != c_ST_IDLE) begin
                if (w_bit_end) begin
                    r_cyc    <= '0;
                    r_bitcnt <= r_bitcnt + c_BW'(1);
                end else begin
                    r_cyc    <= r_cyc + DIV_WIDTH'(1);
                end
            end

            if (w_state_next != r_state) begin
                case (w_state_next)
                    c_ST_START:  r_tx <= 1'b0;
                    c_ST_DATA:   r_tx <= r_shift[0];
`ifdef UART_TX_PARITY_EN
                    c_ST_PARITY: r_tx <= r_par;
`endif
                    default:     r_tx <= 1'b1;
                endcase
            end else if ((r_state == c_ST_DATA) && w_bit_end) begin
                // Next data bit is the one about to shift into position 0.
                r_tx <= r_shift[1];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo
// Purpose  : Directed self-checking bench for uart_tx_fifo. Line activity is
//            captured cycle by cycle on the falling clock edge and compared
//            with hand-derived frame waveforms.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

`ifdef UART_TX_PARITY_EN
    localparam int c_PAR_EN = 1;
`else
    localparam int c_PAR_EN = 0;
`endif
    localparam int c_LOG = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] baud_div = 16'd4;
    logic [1:0]  parity_mode = 2'b00;
    logic        stop2 = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  s_data = 8'h00;
    logic        tx;
    logic        tx_busy;
    logic        tx_done;
    logic [2:0]  fifo_count;

    int checks = 0;
    int errors = 0;

    logic       log_tx    [c_LOG];
    logic       log_done  [c_LOG];
    logic       log_busy  [c_LOG];
    logic       log_ready [c_LOG];
    logic [2:0] log_cnt   [c_LOG];

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .DATA_WIDTH (8),
        .FIFO_DEPTH (4),
        .DIV_WIDTH  (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .baud_div    (baud_div),
        .parity_mode (parity_mode),
        .stop2       (stop2),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .tx          (tx),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .fifo_count  (fifo_count)
    );

    // Expected line level idx cycles into a frame (start bit at idx 0).
    function automatic logic exp_tx(input logic [7:0] d, input int div,
                                    input int par, input logic odd, input int idx);
        int slot;
        slot = idx / div;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return d[slot-1];
        if ((par != 0) && (slot == 9)) return (^d) ^ odd;
        return 1'b1;
    endfunction

    // Samples the current cycle first, then steps one falling edge.
    task automatic record(input int n);
        for (int i = 0; i < n; i++) begin
            log_tx[i]    = tx;
            log_done[i]  = tx_done;
            log_busy[i]  = tx_busy;
            log_ready[i] = s_ready;
            log_cnt[i]   = fifo_count;
            @(negedge clk);
        end
    endtask

    task automatic push_word(input logic [7:0] d);
        s_data  = d;
        s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({tx, s_ready, tx_busy, tx_done} !== 4'b1100 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL reset_values: tx=%b ready=%b busy=%b done=%b count=%0d, expected 1 1 0 0 0",
                     tx, s_ready, tx_busy, tx_done, fifo_count);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({tx, s_ready, tx_busy, tx_done} !== 4'b1100 || fifo_count !== 3'd0) begin
                errors++;
                $display("FAIL idle_cycle %0d: tx=%b ready=%b busy=%b done=%b count=%0d, expected 1 1 0 0 0",
                         i, tx, s_ready, tx_busy, tx_done, fifo_count);
            end
        end
    endtask

    task automatic test_even_parity;
        int flen, bad;
        logic e, got;
        baud_div = 16'd4; parity_mode = 2'b01; stop2 = 1'b0;
        push_word(8'hA5);
        checks++;
        if (tx !== 1'b1 || fifo_count !== 3'd1 || tx_busy !== 1'b1) begin
            errors++;
            $display("FAIL even_after_push: tx=%b count=%0d busy=%b, expected 1 1 1", tx, fifo_count, tx_busy);
        end
        @(negedge clk);
        record(70);
        flen = 4 * (10 + c_PAR_EN);
        bad = -1; e = 1'b0; got = 1'b0;
        for (int i = 0; i < 70; i++) begin
            logic x;
            x = (i < flen) ? exp_tx(8'hA5, 4, c_PAR_EN, 1'b0, i) : 1'b1;
            if (bad < 0 && log_tx[i] !== x) begin bad = i; e = x; got = log_tx[i]; end
        end
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL even_frame: tx=%b at cycle %0d, expected %b", got, bad, e);
        end
        bad = -1;
        for (int i = 0; i < 70; i++)
            if (bad < 0 && log_done[i] !== (i == flen)) bad = i;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL even_done: tx_done=%b at cycle %0d, expected %b", log_done[bad], bad, (bad == flen));
        end
        checks++;
        if (log_busy[flen-1] !== 1'b1 || log_busy[flen] !== 1'b0) begin
            errors++;
            $display("FAIL even_busy: busy=%b,%b around frame end, expected 1,0", log_busy[flen-1], log_busy[flen]);
        end
    endtask

    task automatic test_odd_two_stop;
        int flen, bad;
        logic e, got;
        baud_div = 16'd4; parity_mode = 2'b10; stop2 = 1'b1;
        push_word(8'h01);
        @(negedge clk);
        record(70);
        flen = 4 * (11 + c_PAR_EN);
        bad = -1; e = 1'b0; got = 1'b0;
        for (int i = 0; i < 70; i++) begin
            logic x;
            x = (i < flen) ? exp_tx(8'h01, 4, c_PAR_EN, 1'b1, i) : 1'b1;
            if (bad < 0 && log_tx[i] !== x) begin bad = i; e = x; got = log_tx[i]; end
        end
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL odd_frame: tx=%b at cycle %0d, expected %b", got, bad, e);
        end
        bad = -1;
        for (int i = 0; i < 70; i++)
            if (bad < 0 && log_done[i] !== (i == flen)) bad = i;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL odd_done: tx_done=%b at cycle %0d, expected %b", log_done[bad], bad, (bad == flen));
        end
    endtask

    task automatic test_div_clamp;
        int bad;
        logic e, got;
        baud_div = 16'd0; parity_mode = 2'b00; stop2 = 1'b0;
        push_word(8'h55);
        @(negedge clk);
        record(30);
        bad = -1; e = 1'b0; got = 1'b0;
        for (int i = 0; i < 30; i++) begin
            logic x;
            x = (i < 20) ? exp_tx(8'h55, 2, 0, 1'b0, i) : 1'b1;
            if (bad < 0 && log_tx[i] !== x) begin bad = i; e = x; got = log_tx[i]; end
        end
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL clamp_frame: tx=%b at cycle %0d, expected %b", got, bad, e);
        end
        checks++;
        if (log_done[20] !== 1'b1 || log_done[19] !== 1'b0) begin
            errors++;
            $display("FAIL clamp_done: done=%b,%b at cycles 19,20, expected 0,1", log_done[19], log_done[20]);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] words [6];
        int k, bad, ndone;
        bit saw_full;
        logic e, got;
        for (int i = 0; i < 6; i++) words[i] = 8'h11 + 8'(i);
        baud_div = 16'd3; parity_mode = 2'b00; stop2 = 1'b0;
        k = 0;
        fork
            record(200);
            begin
                logic acc;
                s_data  = words[0];
                s_valid = 1'b1;
                for (int c = 0; c < 190 && k < 6; c++) begin
                    acc = s_ready;
                    @(negedge clk);
                    if (acc) begin
                        k++;
                        if (k < 6) s_data = words[k];
                    end
                end
                s_valid = 1'b0;
            end
        join
        checks++;
        if (k != 6) begin
            errors++;
            $display("FAIL burst_accept: %0d words accepted, expected 6", k);
        end
        bad = -1; e = 1'b0; got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            logic x;
            if (i < 2 || i >= 182) x = 1'b1;
            else x = exp_tx(words[(i-2)/30], 3, 0, 1'b0, (i-2) % 30);
            if (bad < 0 && log_tx[i] !== x) begin bad = i; e = x; got = log_tx[i]; end
        end
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL burst_frames: tx=%b at cycle %0d, expected %b", got, bad, e);
        end
        bad = -1; ndone = 0;
        for (int i = 0; i < 200; i++) begin
            if (log_done[i] === 1'b1) ndone++;
            if (bad < 0 && log_done[i] !== (i >= 32 && i <= 182 && (i-2) % 30 == 0)) bad = i;
        end
        checks++;
        if (bad >= 0 || ndone != 6) begin
            errors++;
            $display("FAIL burst_done: %0d pulses, first misplaced at cycle %0d, expected 6 at 32+30k", ndone, bad);
        end
        bad = -1; saw_full = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (log_cnt[i] === 3'd4) saw_full = 1'b1;
            if (bad < 0 && log_ready[i] !== (log_cnt[i] < 3'd4)) bad = i;
        end
        checks++;
        if (bad >= 0 || !saw_full) begin
            errors++;
            $display("FAIL burst_ready: ready mismatch at cycle %0d, full seen=%b, expected none and 1", bad, saw_full);
        end
        checks++;
        if (log_busy[181] !== 1'b1 || log_busy[182] !== 1'b0 || log_cnt[182] !== 3'd0) begin
            errors++;
            $display("FAIL burst_idle: busy=%b,%b count=%0d at end, expected 1,0 and 0",
                     log_busy[181], log_busy[182], log_cnt[182]);
        end
    endtask

    task automatic test_baud_change;
        int bad;
        logic e, got;
        baud_div = 16'd4; parity_mode = 2'b00; stop2 = 1'b0;
        s_data = 8'h3C; s_valid = 1'b1;
        @(negedge clk);
        s_data = 8'hC3;
        @(negedge clk);
        s_valid = 1'b0;
        fork
            record(140);
            begin
                repeat (10) @(negedge clk);
                baud_div = 16'd8;
            end
        join
        bad = -1; e = 1'b0; got = 1'b0;
        for (int i = 0; i < 140; i++) begin
            logic x;
            if (i < 40)       x = exp_tx(8'h3C, 4, 0, 1'b0, i);
            else if (i < 120) x = exp_tx(8'hC3, 8, 0, 1'b0, i - 40);
            else              x = 1'b1;
            if (bad < 0 && log_tx[i] !== x) begin bad = i; e = x; got = log_tx[i]; end
        end
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL baud_change_frames: tx=%b at cycle %0d, expected %b", got, bad, e);
        end
        bad = -1;
        for (int i = 0; i < 140; i++)
            if (bad < 0 && log_done[i] !== (i == 40 || i == 120)) bad = i;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL baud_change_done: tx_done=%b at cycle %0d, expected pulses at 40 and 120", log_done[bad], bad);
        end
    endtask

    task automatic test_reset_mid_frame;
        int bad;
        baud_div = 16'd4; parity_mode = 2'b00; stop2 = 1'b0;
        s_data = 8'h00; s_valid = 1'b1;
        repeat (3) @(negedge clk);
        s_valid = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (tx !== 1'b0 || fifo_count !== 3'd2 || tx_busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: tx=%b count=%0d busy=%b, expected 0 2 1", tx, fifo_count, tx_busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1 || fifo_count !== 3'd0 || s_ready !== 1'b1 || tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: tx=%b count=%0d ready=%b busy=%b, expected 1 0 1 0",
                     tx, fifo_count, s_ready, tx_busy);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        record(100);
        bad = -1;
        for (int i = 0; i < 100; i++)
            if (bad < 0 && (log_tx[i] !== 1'b1 || log_done[i] !== 1'b0 ||
                            log_cnt[i] !== 3'd0 || log_busy[i] !== 1'b0)) bad = i;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL post_reset_quiet: tx=%b done=%b count=%0d busy=%b at cycle %0d, expected 1 0 0 0",
                     log_tx[bad], log_done[bad], log_cnt[bad], log_busy[bad], bad);
        end
    endtask

    initial begin
        test_reset;
        test_even_parity;
        test_odd_two_stop;
        test_div_clamp;
        test_back_to_back;
        test_baud_change;
        test_reset_mid_frame;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
